// File: rtl/status_pkg.sv
// rtl/status_pkg.sv - shared status level encoding and threshold helper
package status_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_RED    = 2'b10,
    ST_FAULT  = 2'b11
  } status_t;

  function automatic int sat_sub(input int a, input int b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/status_watchdog.sv
// rtl/status_watchdog.sv - flags TIMEOUT consecutive cycles without an accepted sample
module status_watchdog #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sample_valid,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] P_LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // Counter parks at its last value, so expiry keeps asserting until a sample arrives
  assign o_expire = !i_sample_valid && (r_cnt == P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_sample_valid) begin
      r_cnt <= '0;
    end else if (r_cnt != P_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/status_classifier.sv
// rtl/status_classifier.sv - threshold classifier with hysteresis and persistence; STATUS_WATCHDOG_EN adds FAULT timeout
module status_classifier
  import status_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int YEL_TH  = 100,
  parameter int RED_TH  = 200,
  parameter int HYST    = 10,
  parameter int PERSIST = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [1:0]        status_code,
  output logic              status_changed
);

  localparam logic [DATA_W-1:0] P_YEL    = DATA_W'(YEL_TH);
  localparam logic [DATA_W-1:0] P_RED    = DATA_W'(RED_TH);
  localparam logic [DATA_W-1:0] P_YEL_LO = DATA_W'(sat_sub(YEL_TH, HYST));
  localparam logic [DATA_W-1:0] P_RED_LO = DATA_W'(sat_sub(RED_TH, HYST));
  localparam logic [3:0]        P_PERSIST = 4'(PERSIST);

  status_t    r_state;
  status_t    r_cand;
  logic [3:0] r_cnt;
  logic       r_changed;

  status_t    w_raw;
  status_t    w_lvl;
  logic [3:0] w_cnt_next;
  logic       w_expire;

  always_comb begin
    w_raw = ST_GREEN;
    if (sample_data >= P_RED)      w_raw = ST_RED;
    else if (sample_data >= P_YEL) w_raw = ST_YELLOW;

    // Hysteresis only holds the current level on the way down; upward moves use the raw level
    w_lvl = w_raw;
    if (r_state == ST_RED && sample_data >= P_RED_LO)
      w_lvl = ST_RED;
    else if (r_state == ST_YELLOW && w_raw != ST_RED && sample_data >= P_YEL_LO)
      w_lvl = ST_YELLOW;

    w_cnt_next = (w_lvl == r_cand) ? (r_cnt + 4'd1) : 4'd1;
  end

`ifdef STATUS_WATCHDOG_EN
  status_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sample_valid (sample_valid),
    .o_expire       (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_GREEN;
      r_cand    <= ST_GREEN;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (sample_valid) begin
        if (r_state == ST_FAULT) begin
          r_state   <= w_raw;
          r_cand    <= w_raw;
          r_cnt     <= '0;
          r_changed <= 1'b1;
        end else if (w_lvl == r_state) begin
          r_cnt <= '0;
        end else if (w_cnt_next >= P_PERSIST) begin
          r_state   <= w_lvl;
          r_cand    <= w_lvl;
          r_cnt     <= '0;
          r_changed <= 1'b1;
        end else begin
          r_cand <= w_lvl;
          r_cnt  <= w_cnt_next;
        end
      end else if (w_expire && r_state != ST_FAULT) begin
        r_state   <= ST_FAULT;
        r_cnt     <= '0;
        r_changed <= 1'b1;
      end
    end
  end

  assign status_code    = r_state;
  assign status_changed = r_changed;

endmodule

// File: tb/tb_status_classifier.sv
// tb/tb_status_classifier.sv - directed and randomized checks of status_classifier against a level model
module tb_status_classifier;

  localparam int YEL = 100;
  localparam int RED = 200;
  localparam int HY  = 10;
  localparam int PER = 3;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = 8'd0;
  logic [1:0] status_code;
  logic       status_changed;

  int tests = 0;
  int fails = 0;

  // model: levels as integers 0 green, 1 yellow, 2 red, 3 fault
  int m_state, m_cand, m_cnt, m_idle;
  logic [1:0] exp_code;
  logic       exp_chg;

  status_classifier #(
    .DATA_W(8), .YEL_TH(YEL), .RED_TH(RED), .HYST(HY), .PERSIST(PER), .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .status_code    (status_code),
    .status_changed (status_changed)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "[TB] time limit");
  end

  task automatic model_reset();
    m_state = 0; m_cand = 0; m_cnt = 0; m_idle = 0;
    exp_code = 2'b00; exp_chg = 1'b0;
  endtask

  task automatic commit(input int lvl);
    exp_chg = (lvl != m_state);
    m_state = lvl;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic v, input int d);
    int raw, lvl;
    exp_chg = 1'b0;
    if (v) begin
      m_idle = 0;
      raw = (d >= RED) ? 2 : (d >= YEL) ? 1 : 0;
      if (m_state == 3) begin
        commit(raw);
      end else begin
        lvl = raw;
        if (m_state == 2 && d >= ((RED > HY) ? RED - HY : 0)) lvl = 2;
        if (m_state == 1 && raw < 2 && d >= ((YEL > HY) ? YEL - HY : 0)) lvl = 1;
        if (lvl == m_state) m_cnt = 0;
        else if (lvl == m_cand && m_cnt > 0) m_cnt++;
        else begin m_cand = lvl; m_cnt = 1; end
        if (m_cnt >= PER) commit(lvl);
      end
    end else begin
`ifdef STATUS_WATCHDOG_EN
      m_idle++;
      if (m_idle >= TO && m_state != 3) commit(3);
`endif
    end
    exp_code = 2'(m_state);
  endtask

  task automatic chk(input string tag, input logic [1:0] code_e, input logic chg_e);
    tests++;
    assert (status_code === code_e) else begin
      fails++;
      $error("FAIL %s status_code got=%b want=%b", tag, status_code, code_e);
    end
    tests++;
    assert (status_changed === chg_e) else begin
      fails++;
      $error("FAIL %s status_changed got=%b want=%b", tag, status_changed, chg_e);
    end
  endtask

  task automatic cyc(input logic v, input int d);
    sample_valid = v;
    sample_data  = 8'(d);
    model_step(v, d);
    @(posedge clk); #1;
    chk("model", exp_code, exp_chg);
    @(negedge clk);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("reset", 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v, d;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // persistence
    cyc(1, 150); cyc(1, 150);
    chk("persist_pre", 2'b00, 1'b0);
    cyc(1, 150);
    chk("persist", 2'b01, 1'b1);
    cyc(0, 0);
    chk("persist_pulse_end", 2'b01, 1'b0);

    // hysteresis from red
    repeat (3) cyc(1, 250);
    chk("to_red", 2'b10, 1'b1);
    repeat (3) cyc(1, 195);
    chk("hyst_hold", 2'b10, 1'b0);
    repeat (3) cyc(1, 189);
    chk("hyst_drop", 2'b01, 1'b1);

    // broken run
    do_reset();
    cyc(1, 210); cyc(1, 210); cyc(1, 50); cyc(1, 210); cyc(1, 210);
    chk("broken_hold", 2'b00, 1'b0);
    cyc(1, 210);
    chk("broken_red", 2'b10, 1'b1);

`ifdef STATUS_WATCHDOG_EN
    do_reset();
    repeat (TO - 1) cyc(0, 0);
    chk("wd_pre", 2'b00, 1'b0);
    cyc(0, 0);
    chk("wd_fault", 2'b11, 1'b1);
    cyc(0, 0);
    chk("wd_stay", 2'b11, 1'b0);
    cyc(1, 20);
    chk("wd_recover", 2'b00, 1'b1);
`endif

    // reset mid-run
    do_reset();
    cyc(1, 150); cyc(1, 150);
    do_reset();
    cyc(1, 150);
    chk("reset_midrun", 2'b00, 1'b0);

    // exact thresholds
    do_reset();
    repeat (3) cyc(1, 100);
    chk("edge_yel", 2'b01, 1'b1);
    do_reset();
    repeat (3) cyc(1, 200);
    chk("edge_red", 2'b10, 1'b1);

    // randomized run around the thresholds, including idle gaps
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 9) < 7) ? 1 : 0;
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(0, 255);
        1:       d = $urandom_range(85, 115);
        2:       d = $urandom_range(185, 215);
        default: d = (m_state == 2) ? $urandom_range(180, 255) : $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 99) == 0) repeat (TO + 2) cyc(0, 0);
      cyc(v[0], d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
